// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for memory accesses (RISC-V)
//   - FSM state enum
//   - lsu_misaligned / lsu_illegal request classification helpers
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WB   = 2'd2,
        ST_WR   = 2'd3
    } lsu_state_e;

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Unused encodings, and unsigned variants on a store, are illegal.
    function automatic logic lsu_illegal(input logic [2:0] funct3,
                                         input logic       write);
        logic ill;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = write;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response port from the execute stage plus the
// word-addressed data-memory port.
//   slave  : view of the load/store unit (accepts requests, drives memory)
//   master : view of the environment (execute stage + data memory)
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational data steering for the load/store unit.
//   i_funct3     access size/sign encoding
//   i_addr_lo    byte offset within the word
//   i_mem_rdata  word read from memory
//   i_store_data low-aligned store data
//   o_load_data  selected lane, sign/zero extended
//   o_merged     i_mem_rdata with the store lane replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_rdata,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half-word lanes
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_mem_rdata[7:0];
            2'b01:   w_byte = i_mem_rdata[15:8];
            2'b10:   w_byte = i_mem_rdata[23:16];
            2'b11:   w_byte = i_mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_mem_rdata[31:16];
        end else begin
            w_half = i_mem_rdata[15:0];
        end
    end

    // Extend the selected lane for loads
    always_comb begin
        o_load_data = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_mem_rdata;
            F3_BU:   o_load_data = {24'h00_0000, w_byte};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the store lane, keeping the remaining bytes
    always_comb begin
        o_merged = i_mem_rdata;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'b00:   o_merged[7:0]   = i_store_data[7:0];
                    2'b01:   o_merged[15:8]  = i_store_data[7:0];
                    2'b10:   o_merged[23:16] = i_store_data[7:0];
                    2'b11:   o_merged[31:24] = i_store_data[7:0];
                    default: o_merged        = i_mem_rdata;
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_store_data[15:0];
                end else begin
                    o_merged[15:0]  = i_store_data[15:0];
                end
            end
            default: o_merged = i_store_data;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the CPU data-memory port.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  load_store_unit_if.slave: request/response from execute stage and
//        word-addressed single-port memory (1-cycle registered read, no byte
//        enables). Sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              w_accept;
    logic              w_req_err;
    logic              w_is_sw;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
    assign w_req_err = lsu_misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                       lsu_illegal(bus.req_funct3, bus.req_write);
    assign w_is_sw   = bus.req_write && (bus.req_funct3 == F3_W);

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_mem_rdata  (bus.mem_rdata),
        .i_store_data (r_wdata),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged)
    );

    // Next-state logic; errors answer straight from IDLE, full-word stores skip the read
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_accept) begin
                    w_state_next = ST_IDLE;
                end else if (w_req_err) begin
                    w_state_next = ST_IDLE;
                end else if (w_is_sw) begin
                    w_state_next = ST_WR;
                end else begin
                    w_state_next = ST_RD;
                end
            end
            ST_RD: w_state_next = ST_WB;
            ST_WB: begin
                if (r_write) begin
                    w_state_next = ST_WR;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR:   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, request capture and registered outputs; mem_we clears asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_addr_lo    <= 2'b00;
            r_funct3     <= 3'b000;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_next;
            r_mem_we     <= (w_state_next == ST_WR);
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            if (w_accept) begin
                r_mem_addr <= {2'b00, bus.req_addr[ADDR_W-1:2]};
                r_addr_lo  <= bus.req_addr[1:0];
                r_funct3   <= bus.req_funct3;
                r_write    <= bus.req_write;
                r_wdata    <= bus.req_wdata;
                if (w_req_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b1;
                end else if (w_is_sw) begin
                    r_mem_wdata <= bus.req_wdata;
                end else begin
                    r_mem_wdata <= r_mem_wdata;
                end
            end else if (r_state == ST_WB) begin
                if (r_write) begin
                    r_mem_wdata <= w_merged;
                end else begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
            end else if (r_state == ST_WR) begin
                r_resp_valid <= 1'b1;
            end else begin
                r_mem_wdata <= r_mem_wdata;
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_error = r_resp_error;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit with a 64-word
// data memory and a byte-level reference model of loads/stores.
module tb_load_store_unit;
    logic clk;
    logic rst;
    logic preload;
    int   errors;
    int   checks;
    int   we_count;
    int   resp_count;
    int   exp_resp;
    logic [31:0] mem      [0:63];
    logic [31:0] init_mem [0:63];
    logic [31:0] ref_mem  [0:63];

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with 1-cycle registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end

    // Count write strobes and responses seen at clock edges
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) we_count <= we_count + 1;
        if (bus.resp_valid === 1'b1) resp_count <= resp_count + 1;
    end

    // Reference: byte-addressed semantics computed from the access size
    function automatic void model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic e, output logic [31:0] rd,
                                  output int lat, output logic [31:0] nw);
        int size;
        int off;
        logic [31:0] word;
        logic [31:0] v;
        word = ref_mem[addr[7:2]];
        off  = int'(addr[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        e    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (w && f3[2]) || ((off % size) != 0);
        rd   = 32'h0;
        nw   = word;
        lat  = 1;
        if (!e && w) begin
            lat = (size == 4) ? 2 : 4;
            for (int b = 0; b < size; b++) nw[(off + b) * 8 +: 8] = wd[b * 8 +: 8];
        end else if (!e) begin
            lat = 3;
            v = word >> (off * 8);
            if (size == 1) begin
                v = v & 32'h0000_00FF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'h0000_FFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            rd = v;
        end
    endfunction

    // Issue one request (caller is #1 after an edge with the DUT idle) and check it
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, output logic [31:0] got);
        logic        e;
        logic [31:0] er;
        logic [31:0] nw;
        int          el;
        int          lat;
        int          we0;
        int          idx;
        model(w, f3, addr, wd, e, er, el, nw);
        idx = int'(addr[7:2]);
        we0 = we_count;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: got %b want 1", bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            if (hold) begin
                bus.req_write  = 1'($urandom_range(0, 1));
                bus.req_funct3 = 3'($urandom_range(0, 7));
                bus.req_addr   = $urandom;
                bus.req_wdata  = $urandom;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (lat == 1) begin
                checks++;
                if (bus.mem_addr !== {2'b00, addr[31:2]}) begin
                    errors++;
                    $display("FAIL mem_addr: got %h want %h", bus.mem_addr, {2'b00, addr[31:2]});
                end
            end
            if (bus.mem_we === 1'b1) begin
                checks++;
                if (bus.mem_wdata !== nw) begin
                    errors++;
                    $display("FAIL mem_wdata: got %h want %h", bus.mem_wdata, nw);
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.req_valid = 1'b0;
        exp_resp++;
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout: got no response want latency %0d", el);
        end
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL latency: got %0d want %0d (w=%b f3=%b addr=%h)", lat, el, w, f3, addr);
        end
        checks++;
        if (bus.resp_error !== e || bus.resp_rdata !== er) begin
            errors++;
            $display("FAIL response: got err=%b data=%h want err=%b data=%h", bus.resp_error, bus.resp_rdata, e, er);
        end
        got = bus.resp_rdata;
        checks++;
        if (we_count - we0 != ((w && !e) ? 1 : 0)) begin
            errors++;
            $display("FAIL we_pulses: got %0d want %0d", we_count - we0, (w && !e) ? 1 : 0);
        end
        if (w && !e) ref_mem[idx] = nw;
        checks++;
        if (mem[idx] !== ref_mem[idx]) begin
            errors++;
            $display("FAIL mem_word: got %h want %h at word %0d", mem[idx], ref_mem[idx], idx);
        end
    endtask

    task automatic test_reset();
        preload = 1'b1;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b e=%b we=%b want 0", bus.resp_valid, bus.resp_error, bus.mem_we);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got rd=%h a=%h wd=%h want 0", bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        end
        preload = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_loads();
        logic [31:0] got;
        issue(1'b0, 3'b000, 32'h0D, 32'h0, 1'b0, got);
        checks++;
        if (got !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb: got %h want ffffffaa", got); end
        issue(1'b0, 3'b100, 32'h0D, 32'h0, 1'b0, got);
        checks++;
        if (got !== 32'h0000_00AA) begin errors++; $display("FAIL lbu: got %h want 000000aa", got); end
        issue(1'b0, 3'b101, 32'h0E, 32'h0, 1'b0, got);
        checks++;
        if (got !== 32'h0000_8899) begin errors++; $display("FAIL lhu: got %h want 00008899", got); end
    endtask

    task automatic test_store_byte();
        logic [31:0] got;
        issue(1'b1, 3'b000, 32'h0D, 32'h1122_3344, 1'b0, got);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, got);
        checks++;
        if (got !== 32'h8899_44BB) begin errors++; $display("FAIL sb_readback: got %h want 889944bb", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, got);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, got);
        checks++;
        if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_b2b: got %h want deadbeef", got); end
    endtask

    task automatic test_errors();
        logic [31:0] got;
        int          bad;
        issue(1'b0, 3'b001, 32'h03, 32'h0, 1'b0, got);
        issue(1'b1, 3'b010, 32'h22, 32'h5555_AAAA, 1'b0, got);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, got);
        issue(1'b1, 3'b100, 32'h10, 32'h0000_0077, 1'b0, got);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL err_mem_intact: got %0d changed words want 0", bad); end
    endtask

    task automatic test_hold();
        logic [31:0] got;
        issue(1'b0, 3'b001, 32'h0E, 32'h0, 1'b1, got);
        issue(1'b1, 3'b001, 32'h16, 32'h0000_BEEF, 1'b1, got);
        issue(1'b1, 3'b010, 32'h40, 32'h0BAD_F00D, 1'b1, got);
        issue(1'b0, 3'b101, 32'h16, 32'h0, 1'b1, got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) a[0] = 1'b0;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  1'($urandom_range(0, 1)), got);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid_write();
        int we0;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready0: got %b want 1", bus.req_ready); end
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'h0000_CAFE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rst_mid_in_wr: got we=%b want 1", bus.mem_we); end
        we0 = we_count;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we_drop: got %b want 0", bus.mem_we); end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got ready=%b resp=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
        checks++;
        if (mem[4] !== ref_mem[4] || we_count != we0) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h pulses=%0d want %h pulses=0", mem[4], we_count - we0, ref_mem[4]);
        end
    endtask

    initial begin
        errors = 0; checks = 0; we_count = 0; resp_count = 0; exp_resp = 0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = $urandom;
            ref_mem[i]  = init_mem[i];
        end
        init_mem[3] = 32'h8899_AABB;
        ref_mem[3]  = 32'h8899_AABB;
        test_reset();
        test_loads();
        test_store_byte();
        test_back_to_back();
        test_errors();
        test_hold();
        test_random();
        test_reset_mid_write();
        checks++;
        if (resp_count != exp_resp) begin
            errors++;
            $display("FAIL resp_count: got %0d want %0d", resp_count, exp_resp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory port. Accepts one load/store request at a time from the execute stage (byte address, RISC-V funct3 size/sign encoding) and drives the word-addressed, single-port synchronous data memory (`data_memory`), which has a 1-cycle registered read and no byte enables. Performs word-index translation, sub-word read-modify-write for SB/SH, byte/half extraction with sign/zero extension for loads, and alignment checking. Returns one response per request.

## Interface
- `ADDR_W`, 32: request byte-address width.
- `DATA_W`, 32: data width. Fixed at 32; other values are unsupported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid && req_ready` at rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle pulse per accepted request.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned or illegal funct3; qualified by `resp_valid`.
- `mem_addr`  out  32  word index = {2'b00, addr[31:2]}.
- `mem_wdata`  out  32  full word to write.
- `mem_we`  out  1  write strobe; memory writes at the edge ending the cycle in which it is high.
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem_addr` was presented.

## Operation
- States: IDLE, RD, WB, WR.
- IDLE, on accept:
  - Error (H with addr[0]=1; W with addr[1:0]≠0; funct3 011/110/111; store with funct3 1xx) → stay in IDLE; next cycle `resp_valid=1`, `resp_error=1`, `resp_rdata=0`; no memory access.
  - SW → WR with `mem_wdata=req_wdata`.
  - Loads and SB/SH → RD.
- Request address, funct3, and wdata are registered on accept. Inputs are ignored outside IDLE.
- RD: `mem_addr` presented → WB.
- WB:
  - Load: select lane by addr[1:0] (half uses addr[1]); B/H sign-extend, BU/HU zero-extend; register into `resp_rdata` with `resp_valid` → IDLE.
  - SB/SH: merge the store lane into `mem_rdata`, leaving other bytes intact; register into `mem_wdata` → WR.
- WR: `mem_we=1` → IDLE with `resp_valid=1`, `resp_rdata=0`.
- `mem_addr` holds the registered word index in every state. `mem_we=0` outside WR.
- Back-to-back operation: `resp_valid` coincides with IDLE, so a new request can be accepted in the same cycle as the previous response.

## Timing
- Reset values: state IDLE; `resp_valid`, `resp_error`, `mem_we` = 0; `resp_rdata`, `mem_addr`, `mem_wdata` = 0; `req_ready`=1 immediately after reset.
- Latency is acceptance edge → first cycle of `resp_valid`:
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4 (memory updated at the 3rd edge after acceptance).
- Throughput: one request in flight at a time; `req_ready` low in RD/WB/WR.
- Reset asserted mid-operation: `mem_we` drops asynchronously and no write occurs. The in-flight request is discarded without a response.
- RMW atomicity holds only because this block is the sole writer of the memory port.

## Structure
- Package `lsu_pkg`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, and `lsu_misaligned(funct3, addr[1:0])` function.
- Sub-module `lsu_align` (combinational): load extract/extend and store lane merge. Unit-testable separately.
- Top: FSM plus registers. Estimated 150–250 lines.

## Test plan
- Memory word 3 = 0x8899AABB. LB @0x0D → `resp_rdata=0xFFFFFFAA`, latency 3. LBU @0x0D → 0x000000AA. LHU @0x0E → 0x00008899.
- SB 0x11223344 @0x0D (word 3 = 0x8899AABB) → `mem_we` one cycle, `mem_wdata=0x889944BB`, response 4 cycles after accept. A following LW @0x0C returns 0x889944BB.
- SW 0xDEADBEEF @0x20 → `mem_addr=8`, `mem_we` in the cycle after accept, response at latency 2. Back-to-back LW @0x20 accepted on the response cycle returns 0xDEADBEEF.
- LH @0x03 and SW @0x22 → `resp_error=1`, latency 1, `mem_we` never asserted, memory unchanged.
- `req_valid` held high during RD/WB with changing addr/wdata → ignored; exactly one response per accepted request.
- `rst` pulsed while in WR of an SH → `mem_we` falls immediately, target word unchanged, no `resp_valid`, `req_ready=1` after release.
